modulo_product: RTL

- Computes o_mp = (i_a * 2^K) mod i_n by K iterations of double-and-conditional-subtract.
- Sits directly upstream of the Montgomery multiplier inside the RSA core. It converts the message (and the running base) into the Montgomery domain before they are fed to i_MA_a / i_MA_b.
- Single start/end pulse handshake, mirroring the Montgomery stage.

---
 rtl/rsa_pkg.sv | 11 +
 rtl/modulo_product_if.sv | 25 ++
 rtl/mp_step.sv | 26 ++
 rtl/modulo_product.sv | 102 ++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared RSA-core definitions.
// Holds the datapath width, the word type and the state encoding.
// Both the Montgomery-domain conversion block and the Montgomery
// multiplier use this package.
package rsa_pkg;
    localparam int RSA_WIDTH = 256;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} mp_state_t;

    typedef logic [RSA_WIDTH-1:0] rsa_word_t;
endpackage

// File: rtl/modulo_product_if.sv
// Request/result bundle for modulo_product.
//   i_start : one-cycle request pulse; the block samples it only while idle
//   i_n     : modulus (odd, 1 < n)
//   i_a     : operand (a < n)
//   o_mp    : registered result (a * 2^K) mod n; held until the next result
//   o_end   : one-cycle pulse in the first cycle o_mp shows a new result
//   o_busy  : high from the cycle after acceptance through the o_end cycle
//   o_state : current FSM state, for debug and checkers
// Handshake: one start pulse, no ready signal. A start that arrives while
// o_busy is high is dropped and not queued. Each accepted start yields
// exactly one o_end pulse, unless a reset intervenes.
interface modulo_product_if #(parameter int WIDTH = rsa_pkg::RSA_WIDTH);
    logic             i_start;
    logic [WIDTH-1:0] i_n;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] o_mp;
    logic             o_end;
    logic             o_busy;
    logic [1:0]       o_state;

    modport master (output i_start, i_n, i_a,
                    input  o_mp, o_end, o_busy, o_state);
    modport slave  (input  i_start, i_n, i_a,
                    output o_mp, o_end, o_busy, o_state);
endinterface

// File: rtl/mp_step.sv
// One double-and-conditional-subtract step: o_t = (2*i_t) mod i_n,
// provided that i_t < i_n. This module is purely combinational.
//   i_t : current residue (WIDTH bits)
//   i_n : modulus (WIDTH bits)
//   o_t : next residue (WIDTH bits)
module mp_step
    import rsa_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH
) (
    input  logic [WIDTH-1:0] i_t,
    input  logic [WIDTH-1:0] i_n,
    output logic [WIDTH-1:0] o_t
);
    logic [WIDTH:0] d;
    logic [WIDTH:0] n_ext;
    logic           ge;

    assign d     = {i_t, 1'b0};
    assign n_ext = {1'b0, i_n};
    // The compare runs at full WIDTH+1 bits so that a carry out of the doubling is not lost.
    assign ge    = (d >= n_ext);
    // When ge is set the true difference is below 2^WIDTH. Its low WIDTH
    // bits therefore equal the WIDTH-bit modular difference computed here.
    assign o_t   = ge ? (d[WIDTH-1:0] - i_n) : d[WIDTH-1:0];
endmodule

// File: rtl/modulo_product.sv
// Converts an operand into the Montgomery domain: o_mp = (a * 2^K) mod n.
// It runs K double-and-conditional-subtract iterations, one per clock.
//   i_clk : clock, rising edge
//   i_rst : synchronous active-high reset
//   bus   : modulo_product_if slave (start/n/a in; mp/end/busy/state out)
// Latency: a start accepted at edge E0 gives o_end high in the cycle
// after edge E0+K+1.
module modulo_product
    import rsa_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH,
    parameter int K     = RSA_WIDTH
) (
    input  logic            i_clk,
    input  logic            i_rst,
    modulo_product_if.slave bus
);
    localparam int CW = $clog2(K + 1);

    localparam logic [1:0] ST_IDLE = S_IDLE;
    localparam logic [1:0] ST_CALC = S_CALC;
    localparam logic [1:0] ST_DONE = S_DONE;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] t_q, t_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] mp_q, mp_d;
    logic             end_q, end_d;
    logic [WIDTH-1:0] t_next;

    mp_step #(.WIDTH(WIDTH)) u_step (
        .i_t (t_q),
        .i_n (n_q),
        .o_t (t_next)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        t_d     = t_q;
        n_d     = n_q;
        mp_d    = mp_q;
        end_d   = end_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_start) begin
                    t_d     = bus.i_a;
                    n_d     = bus.i_n;
                    cnt_d   = '0;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                t_d   = t_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(K - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // The first DONE cycle publishes the result. The block
                // stays in DONE while o_end is visible, so o_busy also
                // covers the o_end cycle.
                if (!end_q) begin
                    mp_d  = t_q;
                    end_d = 1'b1;
                end else begin
                    end_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                end_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            t_q     <= '0;
            n_q     <= '0;
            mp_q    <= '0;
            end_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            t_q     <= t_d;
            n_q     <= n_d;
            mp_q    <= mp_d;
            end_q   <= end_d;
        end
    end

    assign bus.o_mp    = mp_q;
    assign bus.o_end   = end_q;
    assign bus.o_busy  = (state_q != ST_IDLE);
    assign bus.o_state = state_q;
endmodule
